// File: rtl/spi_flash_rd_seq.sv
// spi_flash_rd_seq: turns one flash read request into a full SPI READ
// transaction driven through the byte-wide SPI master register port
// (Wishbone), streaming returned data bytes out on a valid/ready port.
// Optional build macro: FAST_READ_EN selects command 0x0B with one dummy
// byte after the address instead of plain READ (0x03).
module spi_flash_rd_seq #(
  parameter int         LEN_W    = 8,
  parameter logic [7:0] CS_MASK  = 8'h01,
  parameter logic [7:0] SPCR_CFG = 8'h40,
  parameter logic [7:0] SPER_CFG = 8'h00,
  parameter int         RX_DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [23:0]      req_addr_i,
  input  logic [LEN_W-1:0] req_len_i,
  output logic [7:0]       rd_data_o,
  output logic             rd_valid_o,
  input  logic             rd_ready_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             wb_cyc_o,
  output logic             wb_stb_o,
  output logic [2:0]       wb_adr_o,
  output logic             wb_we_o,
  output logic [7:0]       wb_dat_o,
  input  logic [7:0]       wb_dat_i,
  input  logic             wb_ack_i
);

`ifdef FAST_READ_EN
  localparam logic [7:0] CMD = 8'h0B;
  localparam int         HDR = 5;
`else
  localparam logic [7:0] CMD = 8'h03;
  localparam int         HDR = 4;
`endif
  // tx_left holds header + up to 2^LEN_W data bytes
  localparam int CNT_W = LEN_W + 2;
  localparam int INF_W = $clog2(RX_DEPTH + 1);

  localparam logic [2:0] A_SPCR = 3'd0;
  localparam logic [2:0] A_SPSR = 3'd1;
  localparam logic [2:0] A_SPDR = 3'd2;
  localparam logic [2:0] A_SPER = 3'd3;
  localparam logic [2:0] A_SSR  = 3'd4;

  typedef enum logic [2:0] {
    IDLE, CFG_SPCR, CFG_SPER, CS_ON, XFER, CS_OFF, DONE
  } state_t;

  state_t           state;
  logic [23:0]      addr_q;
  logic [CNT_W-1:0] tx_left;
  logic [INF_W-1:0] inflight;
  logic [2:0]       discard;
  logic [2:0]       tx_cnt;   // bytes written so far, saturating; selects header byte
  logic             rd_pend;  // status showed rx data, data read must follow

  logic [7:0]       tx_byte;
  logic [2:0]       cfg_adr;
  logic [7:0]       cfg_dat;
  state_t           cfg_nxt;
  logic             can_wr;

  assign can_wr = (tx_left != '0) && (inflight < INF_W'(RX_DEPTH));

  // Outgoing SPI byte: command, address MSB first, then zeros (dummy/filler)
  always_comb begin
    tx_byte = 8'h00;
    case (tx_cnt)
      3'd0:    tx_byte = CMD;
      3'd1:    tx_byte = addr_q[23:16];
      3'd2:    tx_byte = addr_q[15:8];
      3'd3:    tx_byte = addr_q[7:0];
      default: tx_byte = 8'h00;
    endcase
  end

  // Register write and successor for the single-write states
  always_comb begin
    cfg_adr = A_SSR;
    cfg_dat = 8'h00;
    cfg_nxt = DONE;
    case (state)
      CFG_SPCR: begin cfg_adr = A_SPCR; cfg_dat = SPCR_CFG; cfg_nxt = CFG_SPER; end
      CFG_SPER: begin cfg_adr = A_SPER; cfg_dat = SPER_CFG; cfg_nxt = CS_ON;    end
      CS_ON:    begin cfg_adr = A_SSR;  cfg_dat = CS_MASK;  cfg_nxt = XFER;     end
      default:  ;
    endcase
  end

  // Sequencer FSM with bus engine; access ends on ack, leaving one idle cycle
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= IDLE;
      addr_q      <= '0;
      tx_left     <= '0;
      inflight    <= '0;
      discard     <= '0;
      tx_cnt      <= '0;
      rd_pend     <= 1'b0;
      req_ready_o <= 1'b1;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      rd_valid_o  <= 1'b0;
      rd_data_o   <= '0;
      wb_cyc_o    <= 1'b0;
      wb_stb_o    <= 1'b0;
      wb_adr_o    <= '0;
      wb_we_o     <= 1'b0;
      wb_dat_o    <= '0;
    end else begin
      done_o <= 1'b0;
      if (rd_valid_o && rd_ready_i) rd_valid_o <= 1'b0;
      case (state)
        IDLE: if (req_valid_i) begin
          addr_q      <= req_addr_i;
          tx_left     <= CNT_W'(HDR) + CNT_W'(req_len_i) + CNT_W'(1);
          inflight    <= '0;
          discard     <= 3'(HDR);
          tx_cnt      <= '0;
          rd_pend     <= 1'b0;
          req_ready_o <= 1'b0;
          busy_o      <= 1'b1;
          state       <= CFG_SPCR;
        end
        CFG_SPCR, CFG_SPER, CS_ON, CS_OFF: begin
          if (!wb_cyc_o) begin
            wb_cyc_o <= 1'b1; wb_stb_o <= 1'b1; wb_we_o <= 1'b1;
            wb_adr_o <= cfg_adr; wb_dat_o <= cfg_dat;
          end else if (wb_ack_i) begin
            wb_cyc_o <= 1'b0; wb_stb_o <= 1'b0;
            state    <= cfg_nxt;
            if (state == CS_OFF) done_o <= 1'b1;
          end
        end
        XFER: begin
          if (wb_cyc_o) begin
            if (wb_ack_i) begin
              wb_cyc_o <= 1'b0; wb_stb_o <= 1'b0;
              if (wb_we_o) begin
                tx_left  <= tx_left - CNT_W'(1);
                inflight <= inflight + INF_W'(1);
                if (tx_cnt != 3'd7) tx_cnt <= tx_cnt + 3'd1;
              end else if (wb_adr_o == A_SPSR) begin
                rd_pend <= ~wb_dat_i[0];
              end else begin
                rd_pend  <= 1'b0;
                inflight <= inflight - INF_W'(1);
                if (discard != 3'd0) discard <= discard - 3'd1;
                else begin
                  rd_valid_o <= 1'b1;
                  rd_data_o  <= wb_dat_i;
                end
              end
            end
          end else if (!rd_valid_o) begin
            if (rd_pend) begin
              wb_cyc_o <= 1'b1; wb_stb_o <= 1'b1; wb_we_o <= 1'b0;
              wb_adr_o <= A_SPDR; wb_dat_o <= 8'h00;
            end else if (can_wr) begin
              wb_cyc_o <= 1'b1; wb_stb_o <= 1'b1; wb_we_o <= 1'b1;
              wb_adr_o <= A_SPDR; wb_dat_o <= tx_byte;
            end else if (inflight != '0) begin
              wb_cyc_o <= 1'b1; wb_stb_o <= 1'b1; wb_we_o <= 1'b0;
              wb_adr_o <= A_SPSR; wb_dat_o <= 8'h00;
            end else begin
              state <= CS_OFF;
            end
          end
        end
        DONE: begin
          state       <= IDLE;
          busy_o      <= 1'b0;
          req_ready_o <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A write collision means the in-flight accounting is broken
  assert property (@(posedge clk_i) disable iff (!rst_ni)
    (wb_cyc_o && wb_ack_i && !wb_we_o && wb_adr_o == A_SPSR) |-> !wb_dat_i[6]);

  // The SPI master FIFOs must never be asked to hold more than RX_DEPTH bytes
  assert property (@(posedge clk_i) disable iff (!rst_ni)
    inflight <= INF_W'(RX_DEPTH));

endmodule

// File: tb/tb_spi_flash_rd_seq.sv
// Bench for spi_flash_rd_seq: Wishbone SPI-master + flash model, scoreboard
// of expected read bytes checked by an independent output monitor.
module tb_spi_flash_rd_seq;
`ifdef FAST_READ_EN
  localparam int         HDR = 5;
  localparam logic [7:0] CMD = 8'h0B;
`else
  localparam int         HDR = 4;
  localparam logic [7:0] CMD = 8'h03;
`endif

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic [23:0] req_addr_i = '0;
  logic [7:0]  req_len_i = '0;
  logic [7:0]  rd_data_o;
  logic        rd_valid_o;
  logic        rd_ready_i = 1'b0;
  logic        busy_o, done_o;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [2:0]  wb_adr_o;
  logic [7:0]  wb_dat_o, wb_dat_i;
  logic        wb_ack_i;

  always #5 clk_i = ~clk_i;

  spi_flash_rd_seq dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_addr_i(req_addr_i), .req_len_i(req_len_i),
    .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o), .rd_ready_i(rd_ready_i),
    .busy_o(busy_o), .done_o(done_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_adr_o(wb_adr_o),
    .wb_we_o(wb_we_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i)
  );

  int checks = 0;
  int errors = 0;
  logic [7:0]  exp_q[$];
  logic [10:0] wlog[$];
  int popped, done_cnt, proto_err, cyc_cnt;
  int rdy_mode = 0;

  function automatic logic [7:0] mem(input logic [23:0] a);
    return a[7:0] + {a[14:8], 1'b0} + a[23:16] + 8'h11;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  // SPI master + flash model: registered ack, 5-cycle shift per byte
  logic        ack_r;
  logic [7:0]  dat_r, sh_resp;
  logic [7:0]  tx_q[$], rx_q[$];
  int          infl, infl_max, sh_cnt, fl_idx;
  logic [23:0] fl_addr;
  assign wb_ack_i = ack_r;
  assign wb_dat_i = dat_r;

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ack_r <= 1'b0; dat_r <= '0; infl <= 0; infl_max <= 0;
      sh_cnt <= 0; fl_idx <= 0; fl_addr <= '0; sh_resp <= '0;
      tx_q.delete(); rx_q.delete();
    end else begin
      ack_r <= 1'b0;
      if (infl > infl_max) infl_max <= infl;
      if (wb_cyc_o && wb_stb_o && !ack_r) begin
        ack_r <= 1'b1;
        if (wb_we_o) begin
          wlog.push_back({wb_adr_o, wb_dat_o});
          if (wb_adr_o == 3'd2) begin tx_q.push_back(wb_dat_o); infl <= infl + 1; end
          if (wb_adr_o == 3'd4) fl_idx <= 0;
        end else if (wb_adr_o == 3'd1) begin
          dat_r <= {7'b0, rx_q.size() == 0};
        end else if (wb_adr_o == 3'd2) begin
          if (rx_q.size() > 0) dat_r <= rx_q.pop_front();
          else dat_r <= 8'hEE;
          infl <= infl - 1;
        end
      end
      if (sh_cnt == 0) begin
        if (tx_q.size() > 0) begin
          case (fl_idx)
            1: fl_addr[23:16] <= tx_q[0];
            2: fl_addr[15:8]  <= tx_q[0];
            3: fl_addr[7:0]   <= tx_q[0];
            default: ;
          endcase
          sh_resp <= (fl_idx >= HDR) ? mem(fl_addr + 24'(fl_idx - HDR)) : 8'hFF;
          fl_idx  <= fl_idx + 1;
          sh_cnt  <= 5;
          void'(tx_q.pop_front());
        end
      end else begin
        sh_cnt <= sh_cnt - 1;
        if (sh_cnt == 1) rx_q.push_back(sh_resp);
      end
    end
  end

  // Consumer ready driver: 0 tied high, 1 random, 2 held low
  always @(posedge clk_i) begin
    #1;
    case (rdy_mode)
      0:       rd_ready_i = 1'b1;
      1:       rd_ready_i = 1'($urandom_range(0, 1));
      default: rd_ready_i = 1'b0;
    endcase
  end

  // Output monitor: pops the scoreboard on every accepted byte
  always @(negedge clk_i) begin
    if (rst_ni && rd_valid_o && rd_ready_i) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rd_extra: got %0h expected none", rd_data_o);
      end else begin
        if (rd_data_o !== exp_q[0]) begin
          errors++;
          $display("FAIL rd_data[%0d]: got %0h expected %0h", popped, rd_data_o, exp_q[0]);
        end
        void'(exp_q.pop_front());
      end
      popped++;
    end
  end

  // Bus protocol / event monitor
  logic        prev_ack = 1'b0, prev_busy = 1'b0;
  logic [11:0] prev_bus = '0;
  always @(negedge clk_i) begin
    if (!rst_ni) begin
      prev_ack = 1'b0; prev_busy = 1'b0;
    end else begin
      if (prev_ack && wb_cyc_o) proto_err++;
      if (prev_busy && (!wb_cyc_o || !wb_stb_o || {wb_adr_o, wb_we_o, wb_dat_o} != prev_bus)) proto_err++;
      if (wb_cyc_o) cyc_cnt++;
      if (done_o) done_cnt++;
      prev_ack  = wb_cyc_o && wb_ack_i;
      prev_busy = wb_cyc_o && !wb_ack_i;
      prev_bus  = {wb_adr_o, wb_we_o, wb_dat_o};
    end
  end

  task automatic issue(input logic [23:0] a, input logic [7:0] l, input bit hold);
    for (int k = 0; k <= int'(l); k++) exp_q.push_back(mem(a + 24'(k)));
    wlog.delete(); done_cnt = 0; popped = 0; proto_err = 0;
    req_addr_i = a; req_len_i = l; req_valid_i = 1'b1;
    tick(1);
    chk("ready_low_after_accept", {31'b0, req_ready_o}, 0);
    chk("busy_after_accept", {31'b0, busy_o}, 1);
    if (hold) begin req_addr_i = 24'hFFFFFF; req_len_i = 8'h02; tick(20); end
    req_valid_i = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin tick(1); n++; end
    chk({nm, "_done_within_budget"}, {31'b0, done_cnt != 0}, 1);
    tick(3);
  endtask

  task automatic check_txn(input string nm, input logic [23:0] a, input int l);
    logic [10:0] ew[$];
    ew.push_back({3'd0, 8'h40}); ew.push_back({3'd3, 8'h00}); ew.push_back({3'd4, 8'h01});
    ew.push_back({3'd2, CMD});
    ew.push_back({3'd2, a[23:16]}); ew.push_back({3'd2, a[15:8]}); ew.push_back({3'd2, a[7:0]});
    if (HDR == 5) ew.push_back({3'd2, 8'h00});
    for (int k = 0; k <= l; k++) ew.push_back({3'd2, 8'h00});
    ew.push_back({3'd4, 8'h00});
    chk({nm, "_wlog_len"}, wlog.size(), ew.size());
    for (int i = 0; i < ew.size() && i < wlog.size(); i++)
      chk($sformatf("%s_wlog[%0d]", nm, i), {21'b0, wlog[i]}, {21'b0, ew[i]});
    chk({nm, "_done_pulses"}, done_cnt, 1);
    chk({nm, "_bytes_out"}, popped, l + 1);
    chk({nm, "_scoreboard_empty"}, exp_q.size(), 0);
    chk({nm, "_bus_protocol"}, proto_err, 0);
    chk({nm, "_inflight_max"}, infl_max, 4);
    chk({nm, "_idle_ready"}, {30'b0, req_ready_o, busy_o}, 2);
  endtask

  initial begin
    int c0, n, stall_bad;
    logic [7:0] held;
    tick(3);
    rst_ni = 1'b1;
    tick(1);
    // reset / idle
    c0 = cyc_cnt;
    tick(100);
    chk("idle_no_cyc", cyc_cnt - c0, 0);
    chk("idle_ready", {31'b0, req_ready_o}, 1);
    chk("idle_outs", {busy_o, done_o, rd_valid_o, rd_data_o, wb_cyc_o, wb_stb_o, wb_adr_o, wb_we_o, wb_dat_o}, 0);

    // single byte
    issue(24'h012345, 8'd0, 1'b0);
    wait_done("len0", 1000);
    check_txn("len0", 24'h012345, 0);

    // 16 bytes, ready tied high, valid held while busy must be ignored
    issue(24'h00ABC0, 8'd15, 1'b1);
    wait_done("len15", 3000);
    check_txn("len15", 24'h00ABC0, 15);

    // 8 bytes with random back-pressure and a 50-cycle stall
    rdy_mode = 1;
    issue(24'h00A0FC, 8'd7, 1'b0);
    n = 0;
    while (popped < 2 && n < 2000) begin tick(1); n++; end
    rdy_mode = 2;
    tick(2);
    n = 0;
    while (!rd_valid_o && n < 2000) begin tick(1); n++; end
    chk("stall_valid_seen", {31'b0, rd_valid_o}, 1);
    held = rd_data_o; stall_bad = 0;
    repeat (50) begin
      @(negedge clk_i);
      if (!rd_valid_o || rd_data_o !== held || wb_cyc_o) stall_bad++;
    end
    chk("stall_hold", stall_bad, 0);
    tick(1);
    rdy_mode = 1;
    wait_done("stall", 4000);
    check_txn("stall", 24'h00A0FC, 7);
    rdy_mode = 0;

    // reset in the middle of the data phase, then restart
    issue(24'h000200, 8'd15, 1'b0);
    n = 0;
    while (popped < 3 && n < 2000) begin tick(1); n++; end
    chk("midrst_reached_3", {31'b0, popped >= 3}, 1);
    rst_ni = 1'b0;
    tick(2);
    exp_q.delete();
    chk("midrst_outs", {busy_o, done_o, rd_valid_o, wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o}, 0);
    rst_ni = 1'b1;
    tick(2);
    chk("midrst_ready", {31'b0, req_ready_o}, 1);
    issue(24'h000010, 8'd1, 1'b0);
    wait_done("restart", 1000);
    check_txn("restart", 24'h000010, 1);

    // header variant vector
    issue(24'h000100, 8'd3, 1'b0);
    wait_done("hdr", 1000);
    check_txn("hdr", 24'h000100, 3);

    // full length wrap: 256 bytes across the 24-bit address wrap
    issue(24'hFFFF80, 8'hFF, 1'b0);
    wait_done("len256", 20000);
    check_txn("len256", 24'hFFFF80, 255);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
